// File: rtl/dut_pipe_if.sv
// Stream handshake, error-injection control and status bundle for dut_pipe.
// The master side drives the stream and injection inputs. The slave (pipe) side drives ready and status.
interface dut_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             inj_arm;
  logic [CNT_W-1:0] inj_count;
  logic [WIDTH-1:0] inj_mask;
  logic             inj_busy;
  logic             inj_done;
  logic [31:0]      xfer_count;

  modport master (
    output in_valid, in_data, out_ready, inj_arm, inj_count, inj_mask,
    input  in_ready, out_valid, out_data, inj_busy, inj_done, xfer_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, inj_arm, inj_count, inj_mask,
    output in_ready, out_valid, out_data, inj_busy, inj_done, xfer_count
  );
endinterface

// File: rtl/dut_pipe.sv
// Elastic DEPTH-stage valid/ready pipe with a countdown XOR error injector. Latency is DEPTH cycles.
// in_ready is combinational: the pipe fills to DEPTH words under out_ready=0, and a full pipe streams at one word per cycle.
module dut_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       reset,
  dut_pipe_if.slave bus
);
  typedef enum logic {IDLE, ARMED} inj_state_e;

  inj_state_e       state_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] mask_q;
  logic [31:0]      xfer_q;

  logic [DEPTH-1:0] vld_q, vld_d, ld;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];
  logic             in_xfer, out_xfer, fire;

  assign out_xfer = vld_q[DEPTH-1] && bus.out_ready;
  assign in_xfer  = bus.in_valid && ld[0];
  // An arm in the same cycle restarts the countdown, so that transfer is never the corrupted one.
  assign fire     = (state_q == ARMED) && in_xfer && !bus.inj_arm && (rem_q == CNT_W'(1));

  // Stage k may load when it is empty or its word moves on; resolved from the output end backwards.
  always_comb begin : ld_chain
    logic go;
    go = bus.out_ready;
    ld = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      go    = !vld_q[k] || go;
      ld[k] = go;
    end
  end

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (ld[0]) begin
      vld_d[0] = bus.in_valid;
      if (bus.in_valid) dat_d[0] = bus.in_data ^ (fire ? mask_q : '0);
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (ld[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mask_q  <= '0;
    end else if (bus.inj_arm) begin
      if (bus.inj_count != '0) begin
        state_q <= ARMED;
        rem_q   <= bus.inj_count;
        mask_q  <= bus.inj_mask;
      end else begin
        state_q <= IDLE;
        rem_q   <= '0;
      end
    end else if (state_q == ARMED && in_xfer) begin
      if (rem_q == CNT_W'(1)) begin
        state_q <= IDLE;
        rem_q   <= '0;
      end else begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         xfer_q <= '0;
    else if (out_xfer) xfer_q <= xfer_q + 32'd1;
  end

  assign bus.in_ready   = ld[0];
  assign bus.out_valid  = vld_q[DEPTH-1];
  assign bus.out_data   = dat_q[DEPTH-1];
  assign bus.inj_busy   = (state_q == ARMED);
  assign bus.inj_done   = fire;
  assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_dut_pipe.sv
// Bench for dut_pipe: DEPTH=3 for directed and table tests, DEPTH=1 and DEPTH=16 for random stall runs.
// One process drives inputs just after posedge and checks against a queue-based reference model at negedge.
module tb_dut_pipe;
  localparam int W  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]    sel;
  logic          in_valid, out_ready, inj_arm;
  logic [W-1:0]  in_data, inj_mask;
  logic [CW-1:0] inj_count;
  logic          s_in_ready, s_out_valid, s_inj_busy, s_inj_done;
  logic [W-1:0]  s_out_data;
  logic [31:0]   s_xfer;

  dut_pipe_if #(.WIDTH(W), .CNT_W(CW)) b0 ();
  dut_pipe_if #(.WIDTH(W), .CNT_W(CW)) b1 ();
  dut_pipe_if #(.WIDTH(W), .CNT_W(CW)) b2 ();

  dut_pipe #(.WIDTH(W), .DEPTH(3),  .CNT_W(CW)) u_d3  (.clk(clk), .reset(reset), .bus(b0));
  dut_pipe #(.WIDTH(W), .DEPTH(1),  .CNT_W(CW)) u_d1  (.clk(clk), .reset(reset), .bus(b1));
  dut_pipe #(.WIDTH(W), .DEPTH(16), .CNT_W(CW)) u_d16 (.clk(clk), .reset(reset), .bus(b2));

  // Only the selected instance sees traffic; the others sit idle.
  assign b0.in_valid = in_valid && (sel == 2'd0);
  assign b1.in_valid = in_valid && (sel == 2'd1);
  assign b2.in_valid = in_valid && (sel == 2'd2);
  assign b0.out_ready = out_ready && (sel == 2'd0);
  assign b1.out_ready = out_ready && (sel == 2'd1);
  assign b2.out_ready = out_ready && (sel == 2'd2);
  assign b0.inj_arm = inj_arm && (sel == 2'd0);
  assign b1.inj_arm = inj_arm && (sel == 2'd1);
  assign b2.inj_arm = inj_arm && (sel == 2'd2);
  assign b0.in_data = in_data;    assign b1.in_data = in_data;    assign b2.in_data = in_data;
  assign b0.inj_count = inj_count; assign b1.inj_count = inj_count; assign b2.inj_count = inj_count;
  assign b0.inj_mask = inj_mask;  assign b1.inj_mask = inj_mask;  assign b2.inj_mask = inj_mask;

  always_comb begin
    s_in_ready = b0.in_ready; s_out_valid = b0.out_valid; s_out_data = b0.out_data;
    s_inj_busy = b0.inj_busy; s_inj_done = b0.inj_done; s_xfer = b0.xfer_count;
    if (sel == 2'd1) begin
      s_in_ready = b1.in_ready; s_out_valid = b1.out_valid; s_out_data = b1.out_data;
      s_inj_busy = b1.inj_busy; s_inj_done = b1.inj_done; s_xfer = b1.xfer_count;
    end else if (sel == 2'd2) begin
      s_in_ready = b2.in_ready; s_out_valid = b2.out_valid; s_out_data = b2.out_data;
      s_inj_busy = b2.inj_busy; s_inj_done = b2.inj_done; s_xfer = b2.xfer_count;
    end
  end

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           m_busy;
  int           m_rem;
  logic [W-1:0] m_mask;
  int           rcv;
  bit           acc, acc_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model and scoreboard, evaluated for the edge that follows.
  task automatic monitor();
    bit xin, fire;
    logic [W-1:0] e;
    acc = 0; acc_done = 0;
    if (reset) begin
      exp_q.delete(); m_busy = 0; m_rem = 0; m_mask = '0;
      return;
    end
    xin  = in_valid && s_in_ready;
    fire = m_busy && xin && !inj_arm && (m_rem == 1);
    chk("inj_done", s_inj_done, fire);
    chk("inj_busy", s_inj_busy, m_busy);
    if (s_out_valid && out_ready) begin
      rcv++;
      got_q.push_back(s_out_data);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL out_unexpected: got 0x%0h expected no output", s_out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", s_out_data, e);
      end
    end
    if (xin) begin
      exp_q.push_back(in_data ^ (fire ? m_mask : '0));
      acc = 1; acc_done = s_inj_done;
    end
    if (inj_arm) begin
      if (inj_count != 0) begin m_busy = 1; m_rem = int'(inj_count); m_mask = inj_mask; end
      else m_busy = 0;
    end else if (m_busy && xin) begin
      if (m_rem == 1) m_busy = 0;
      else m_rem--;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1; in_data = d;
    for (int t = 0; t < 200; t++) begin
      step();
      if (acc) break;
    end
    if (!acc) begin n_cmp++; n_bad++; $display("FAIL send_timeout: got no accept expected accept of 0x%0h", d); end
  endtask

  task automatic arm(input logic [CW-1:0] c, input logic [W-1:0] m);
    in_valid = 0; inj_arm = 1; inj_count = c; inj_mask = m;
    step();
    inj_arm = 0; inj_count = '0; inj_mask = 8'h5A;
  endtask

  task automatic drain(input int n);
    in_valid = 0;
    for (int t = 0; t < 500 && got_q.size() < n; t++) step();
    if (got_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d words expected %0d", got_q.size(), n);
    end
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; inj_arm = 0;
    step(); step();
    reset = 0; got_q.delete(); rcv = 0;
  endtask

  typedef struct {
    logic          arm;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mask;
    logic [W-1:0]  dat;
    logic [W-1:0]  exp;
    logic          done;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int idx, sent;
    tbl[0]  = '{1'b0, 16'd0, 8'h00, 8'h01, 8'h01, 1'b0};
    tbl[1]  = '{1'b0, 16'd0, 8'h00, 8'h02, 8'h02, 1'b0};
    tbl[2]  = '{1'b0, 16'd0, 8'h00, 8'h03, 8'h03, 1'b0};
    tbl[3]  = '{1'b1, 16'd2, 8'hFF, 8'h10, 8'h10, 1'b0};
    tbl[4]  = '{1'b0, 16'd0, 8'h00, 8'h20, 8'hDF, 1'b1};
    tbl[5]  = '{1'b0, 16'd0, 8'h00, 8'h30, 8'h30, 1'b0};
    tbl[6]  = '{1'b1, 16'd1, 8'h0F, 8'h40, 8'h4F, 1'b1};
    tbl[7]  = '{1'b1, 16'd3, 8'h80, 8'h55, 8'h55, 1'b0};
    tbl[8]  = '{1'b0, 16'd0, 8'h00, 8'h66, 8'h66, 1'b0};
    tbl[9]  = '{1'b0, 16'd0, 8'h00, 8'h77, 8'hF7, 1'b1};
    tbl[10] = '{1'b1, 16'd2, 8'h01, 8'h99, 8'h99, 1'b0};
    tbl[11] = '{1'b1, 16'd0, 8'hFF, 8'hAA, 8'hAA, 1'b0};
    tbl[12] = '{1'b1, 16'd1, 8'hFF, 8'h00, 8'hFF, 1'b1};
    tbl[13] = '{1'b1, 16'd3, 8'h01, 8'hB0, 8'hB0, 1'b0};
    tbl[14] = '{1'b1, 16'd2, 8'h02, 8'hC0, 8'hC0, 1'b0};
    tbl[15] = '{1'b0, 16'd0, 8'h00, 8'hD0, 8'hD2, 1'b1};

    sel = 2'd0; reset = 1; in_valid = 0; in_data = '0; out_ready = 1;
    inj_arm = 0; inj_count = '0; inj_mask = '0;
    m_busy = 0; m_rem = 0; m_mask = '0; rcv = 0;
    do_reset();
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_inj_busy", s_inj_busy, 0);
    chk("rst_inj_done", s_inj_done, 0);
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_xfer_count", s_xfer, 0);

    // Latency of exactly DEPTH=3 and back-to-back throughput.
    send(8'h01);
    send(8'h02);
    chk("lat_not_early", s_out_valid, 0);
    send(8'h03);
    chk("lat_valid", s_out_valid, 1);
    chk("lat_data0", s_out_data, 8'h01);
    in_valid = 0;
    step(); chk("lat_data1", s_out_data, 8'h02);
    step(); chk("lat_data2", s_out_data, 8'h03);
    step(); chk("lat_xfer_count", s_xfer, 3);

    // Table: injection arming, restart, cancel and mask latching.
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].arm) arm(tbl[i].cnt, tbl[i].mask);
      send(tbl[i].dat);
      chk($sformatf("tbl_done[%0d]", i), acc_done, tbl[i].done);
    end
    drain(16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk($sformatf("tbl_out[%0d]", i), got_q[i], tbl[i].exp);
    chk("tbl_busy_end", s_inj_busy, 0);

    // Backpressure: pipe fills to 3 words then stalls, output held stable.
    got_q.delete();
    out_ready = 0; idx = 1; in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      in_data = idx[W-1:0];
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", idx - 1, 3);
    chk("bp_in_ready", s_in_ready, 0);
    chk("bp_out_valid", s_out_valid, 1);
    chk("bp_out_hold", s_out_data, 8'h01);
    out_ready = 1;
    send(8'h04);
    send(8'h05);
    drain(5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("bp_out[%0d]", i), got_q[i], W'(i + 1));

    // Arm coincident with a transfer: that transfer is not counted.
    got_q.delete();
    in_valid = 1; in_data = 8'hAA; inj_arm = 1; inj_count = 16'd2; inj_mask = 8'hFF;
    step();
    chk("co_accept", acc, 1);
    inj_arm = 0; inj_mask = 8'h00;
    send(8'h11);
    send(8'h22);
    chk("co_done", acc_done, 1);
    drain(3);
    if (got_q.size() == 3) begin
      chk("co_out0", got_q[0], 8'hAA);
      chk("co_out1", got_q[1], 8'h11);
      chk("co_out2", got_q[2], 8'hDD);
    end

    // Reset with words in flight and an armed injection.
    got_q.delete();
    out_ready = 0;
    send(8'h41);
    send(8'h42);
    arm(16'd1, 8'hFF);
    chk("mid_busy", s_inj_busy, 1);
    reset = 1;
    step();
    reset = 0;
    chk("mid_out_valid", s_out_valid, 0);
    chk("mid_inj_busy", s_inj_busy, 0);
    chk("mid_xfer_count", s_xfer, 0);
    chk("mid_in_ready", s_in_ready, 1);
    out_ready = 1; got_q.delete(); rcv = 0;
    send(8'h31);
    send(8'h32);
    send(8'h33);
    drain(3);
    if (got_q.size() == 3) begin
      chk("mid_out0", got_q[0], 8'h31);
      chk("mid_out1", got_q[1], 8'h32);
      chk("mid_out2", got_q[2], 8'h33);
    end

    // Random stalls and occasional arms on DEPTH=1 and DEPTH=16.
    for (int s = 1; s <= 2; s++) begin
      sel = 2'(s);
      do_reset();
      sent = 0;
      for (int c = 0; c < 40000 && rcv < 10000; c++) begin
        in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
        in_data   = W'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        inj_arm   = ($urandom_range(0, 199) == 0);
        inj_count = CW'($urandom_range(0, 4));
        inj_mask  = W'($urandom);
        step();
        if (acc) sent++;
      end
      in_valid = 0; inj_arm = 0; out_ready = 1;
      chk($sformatf("rnd%0d_received", s), rcv, 10000);
      chk($sformatf("rnd%0d_xfer_count", s), s_xfer, 32'(rcv));
      chk($sformatf("rnd%0d_sb_empty", s), exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
